// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences memory, register file and ALU per instruction.
// Outputs are combinational from state and inputs; FETCH/MEMREAD/MEMWRITE stall on mem_ready; TRAP holds until reset.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [3:0] state_q, state_d, cur;
  logic [1:0] aluop;
  logic       pcupdate, branch;
  logic       mem_req_c, memwrite_c, irwrite_c, regwrite_c, done_c;

  // While reset is held the decode behaves as FETCH; enables are masked below.
  assign cur = reset ? state_q : S_FETCH;

  always_comb begin
    state_d    = state_q;
    mem_req_c  = 1'b0;
    adrsrc     = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    done_c     = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite_c = mem_ready;
        pcupdate  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_IALU:      state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adrsrc    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc  = 2'b01;
        regwrite_c = 1'b1;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c  = 1'b1;
        adrsrc     = 1'b1;
        memwrite_c = 1'b1;
        done_c     = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign mem_req    = reset & mem_req_c;
  assign memwrite   = reset & memwrite_c;
  assign irwrite    = reset & irwrite_c;
  assign regwrite   = reset & regwrite_c;
  assign instr_done = reset & done_c;
  assign pcwrite    = reset & (pcupdate | (branch & zero));

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // Subtract only for R-type (op[5]) with funct7b5; addi ignores funct7b5.
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed cycle-by-cycle stimulus for multicycle_ctrl; expected output vectors queued and checked by a negedge monitor.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [2:0] alucontrol;
    logic       instr_done;
    logic       illegal;
  } out_t;

  logic       clk = 1'b1;
  logic       reset = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, adrsrc, memwrite, irwrite, pcwrite, regwrite, instr_done, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  out_t       act;

  int checks = 0;
  int errors = 0;
  out_t  exp_q[$];
  string tag_q[$];

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adrsrc(adrsrc),
    .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc),
    .alucontrol(alucontrol), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, adrsrc, memwrite, irwrite, pcwrite, regwrite, resultsrc,
                alusrca, alusrcb, immsrc, alucontrol, instr_done, illegal};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] BQ = 7'b1100011, IA = 7'b0010011, JL = 7'b1101111, BAD = 7'b1111111;

  function automatic out_t mk(input logic mr, as, mw, ir, pw, rw,
                              input logic [1:0] res, sa, sb, imm,
                              input logic [2:0] alu, input logic dn, il);
    return {mr, as, mw, ir, pw, rw, res, sa, sb, imm, alu, dn, il};
  endfunction

  // One clock cycle: drive inputs, queue the hand-derived expected outputs, advance.
  task automatic cyc(input string tag, input logic rst, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy, input out_t e);
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s actual=%05h required=%05h", t, act, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] f3;
    logic       f7;
    logic [2:0] alu;
  } ivec_t;

  ivec_t ivecs[5];

  initial begin
    ivecs[0] = '{3'b010, 1'b0, 3'b101};
    ivecs[1] = '{3'b110, 1'b0, 3'b011};
    ivecs[2] = '{3'b111, 1'b0, 3'b010};
    ivecs[3] = '{3'b000, 1'b1, 3'b000};
    ivecs[4] = '{3'b001, 1'b0, 3'b000};

    // Reset: enables forced low even with mem_ready high; muxes show FETCH values.
    cyc("reset0", 0, RT, 3'b000, 0, 0, 1, mk(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("reset1", 0, RT, 3'b000, 0, 0, 1, mk(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));

    // R-type add
    cyc("add_fetch",  1, RT, 3'b000, 0, 0, 1, mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("add_decode", 1, RT, 3'b000, 0, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("add_execr",  1, RT, 3'b000, 0, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0,0));
    cyc("add_aluwb",  1, RT, 3'b000, 0, 0, 1, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));

    // R-type sub
    cyc("sub_fetch",  1, RT, 3'b000, 1, 0, 1, mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("sub_decode", 1, RT, 3'b000, 1, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("sub_execr",  1, RT, 3'b000, 1, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0));
    cyc("sub_aluwb",  1, RT, 3'b000, 1, 0, 1, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));

    // lw with 2 FETCH waits and 3 MEMREAD waits: instr_done in cycle 10
    cyc("lw_fwait1", 1, LW, 3'b010, 0, 0, 0, mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("lw_fwait2", 1, LW, 3'b010, 0, 0, 0, mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("lw_fetch",  1, LW, 3'b010, 0, 0, 1, mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("lw_decode", 1, LW, 3'b010, 0, 0, 0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("lw_memadr", 1, LW, 3'b010, 0, 0, 0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
    for (int i = 0; i < 3; i++)
      cyc("lw_rwait", 1, LW, 3'b010, 0, 0, 0, mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    cyc("lw_memread", 1, LW, 3'b010, 0, 0, 1, mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    cyc("lw_memwb",   1, LW, 3'b010, 0, 0, 0, mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,1,0));

    // beq taken then not taken
    cyc("beq1_fetch",  1, BQ, 3'b000, 0, 1, 1, mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
    cyc("beq1_decode", 1, BQ, 3'b000, 0, 1, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
    cyc("beq1_beq",    1, BQ, 3'b000, 0, 1, 1, mk(0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b10,3'b001,1,0));
    cyc("beq0_fetch",  1, BQ, 3'b000, 0, 0, 1, mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
    cyc("beq0_decode", 1, BQ, 3'b000, 0, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
    cyc("beq0_beq",    1, BQ, 3'b000, 0, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,1,0));

    // sw with 2 MEMWRITE waits
    cyc("sw_fetch",  1, SW, 3'b010, 0, 0, 1, mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
    cyc("sw_decode", 1, SW, 3'b010, 0, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0));
    cyc("sw_memadr", 1, SW, 3'b010, 0, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
    cyc("sw_wwait1", 1, SW, 3'b010, 0, 0, 0, mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
    cyc("sw_wwait2", 1, SW, 3'b010, 0, 0, 0, mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
    cyc("sw_write",  1, SW, 3'b010, 0, 0, 1, mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,1,0));

    // jal
    cyc("jal_fetch",  1, JL, 3'b000, 0, 0, 1, mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b11,3'b000,0,0));
    cyc("jal_decode", 1, JL, 3'b000, 0, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0,0));
    cyc("jal_jal",    1, JL, 3'b000, 0, 0, 1, mk(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,0));
    cyc("jal_aluwb",  1, JL, 3'b000, 0, 0, 1, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,1,0));

    // I-type ALU funct3 variants
    foreach (ivecs[k]) begin
      cyc("i_fetch",  1, IA, ivecs[k].f3, ivecs[k].f7, 0, 1, mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      cyc("i_decode", 1, IA, ivecs[k].f3, ivecs[k].f7, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
      cyc("i_execi",  1, IA, ivecs[k].f3, ivecs[k].f7, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,ivecs[k].alu,0,0));
      cyc("i_aluwb",  1, IA, ivecs[k].f3, ivecs[k].f7, 0, 1, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
    end

    // Illegal opcode: TRAP holds with no enables until reset
    cyc("bad_fetch",  1, BAD, 3'b000, 0, 1, 1, mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("bad_decode", 1, BAD, 3'b000, 0, 1, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    for (int i = 0; i < 10; i++)
      cyc("trap_hold", 1, BAD, 3'b000, 0, 1, 1, mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,1));
    cyc("trap_reset", 0, BAD, 3'b000, 0, 1, 1, mk(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("post_trap_fetch", 1, BAD, 3'b000, 0, 0, 0, mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));

    // Reset during a MEMREAD wait returns to FETCH without regwrite
    cyc("rl_fetch",  1, LW, 3'b010, 0, 0, 1, mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("rl_decode", 1, LW, 3'b010, 0, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("rl_memadr", 1, LW, 3'b010, 0, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
    cyc("rl_rwait",  1, LW, 3'b010, 0, 0, 0, mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    cyc("rl_reset",  0, LW, 3'b010, 0, 0, 1, mk(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("rl_refetch", 1, LW, 3'b010, 0, 0, 0, mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("rl_fetch2", 1, LW, 3'b010, 0, 0, 1, mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
